// File: rtl/common_pipeline_fifo_buffer.sv
// Fully registered pipeline FIFO: data, valid and ready all come from flops,
// so no combinational path crosses between the two neighbouring stages.

module stdmacro_dffe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module common_pipeline_fifo_buffer #(
    parameter int BUFFER_WIDTH = 1,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [BUFFER_WIDTH-1:0]           prev_i_data,
    input  logic                              prev_i_valid,
    output logic                              prev_o_ready,
    output logic [BUFFER_WIDTH-1:0]           next_o_data,
    output logic                              next_o_valid,
    input  logic                              next_i_ready,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);

    logic [BUFFER_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [BUFFER_DEPTH-1:0] wr_en;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    logic             valid_q;
    logic             push;
    logic             pop;

    assign push = prev_i_valid & ready_q;
    assign pop  = valid_q & next_i_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths stay in range.
            if (push) begin
                wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PTR_W'(1);
            end
            unique case (1'b1)
                (push & ~pop): count_d = count_q + CNT_W'(1);
                (pop & ~push): count_d = count_q - CNT_W'(1);
                default:       count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ready_q <= (count_d != FULL);
            valid_q <= (count_d != '0);
        end
    end

    for (genvar i = 0; i < BUFFER_DEPTH; i++) begin : g_entry
        assign wr_en[i] = push & ~flush & (wptr_q == PTR_W'(i));

        stdmacro_dffe #(
            .WIDTH(BUFFER_WIDTH)
        ) u_dffe (
            .clk  (clk),
            .reset(reset),
            .en   (wr_en[i]),
            .d    (prev_i_data),
            .q    (mem[i])
        );
    end

    assign prev_o_ready = ready_q;
    assign next_o_valid = valid_q;
    assign next_o_data  = mem[rptr_q];
    assign occupancy    = count_q;

endmodule

// File: tb/tb_common_pipeline_fifo_buffer.sv
// Directed bench for common_pipeline_fifo_buffer at depth 4 and depth 3.

module tb_common_pipeline_fifo_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // depth-4 instance
    logic       a_reset, a_flush, a_pvalid, a_pready, a_nvalid, a_nready;
    logic [7:0] a_pdata, a_ndata;
    logic [2:0] a_occ;

    // depth-3 instance
    logic       b_reset, b_flush, b_pvalid, b_pready, b_nvalid, b_nready;
    logic [7:0] b_pdata, b_ndata;
    logic [1:0] b_occ;

    common_pipeline_fifo_buffer #(
        .BUFFER_WIDTH(8),
        .BUFFER_DEPTH(4)
    ) dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .flush       (a_flush),
        .prev_i_data (a_pdata),
        .prev_i_valid(a_pvalid),
        .prev_o_ready(a_pready),
        .next_o_data (a_ndata),
        .next_o_valid(a_nvalid),
        .next_i_ready(a_nready),
        .occupancy   (a_occ)
    );

    common_pipeline_fifo_buffer #(
        .BUFFER_WIDTH(8),
        .BUFFER_DEPTH(3)
    ) dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .flush       (b_flush),
        .prev_i_data (b_pdata),
        .prev_i_valid(b_pvalid),
        .prev_o_ready(b_pready),
        .next_o_data (b_ndata),
        .next_o_valid(b_nvalid),
        .next_i_ready(b_nready),
        .occupancy   (b_occ)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_reset  = 1'b1;
        a_flush  = 1'b0;
        a_pvalid = 1'b0;
        a_nready = 1'b0;
        a_pdata  = 8'h00;
        step();
        a_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_a();
        total++;
        if (a_nvalid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", a_nvalid);
        else passed++;
        total++;
        if (a_pready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", a_pready);
        else passed++;
        total++;
        if (a_occ !== 3'd0) $display("FAIL rst_occ: got %0d exp 0", a_occ);
        else passed++;
        total++;
        if (a_ndata !== 8'h00) $display("FAIL rst_data: got %h exp 00", a_ndata);
        else passed++;
    endtask

    task automatic test_latency();
        a_pvalid = 1'b1;
        a_pdata  = 8'h11;
        #2;
        total++;
        if (a_nvalid !== 1'b0) $display("FAIL lat_bypass: got %b exp 0", a_nvalid);
        else passed++;
        step();
        a_pvalid = 1'b0;
        total++;
        if (a_nvalid !== 1'b1) $display("FAIL lat_valid: got %b exp 1", a_nvalid);
        else passed++;
        total++;
        if (a_ndata !== 8'h11) $display("FAIL lat_data: got %h exp 11", a_ndata);
        else passed++;
        total++;
        if (a_occ !== 3'd1) $display("FAIL lat_occ: got %0d exp 1", a_occ);
        else passed++;
    endtask

    task automatic test_full();
        reset_a();
        for (int i = 0; i < 4; i++) begin
            a_pvalid = 1'b1;
            a_pdata  = 8'hA0 + 8'(i);
            step();
        end
        total++;
        if (a_pready !== 1'b0) $display("FAIL full_ready: got %b exp 0", a_pready);
        else passed++;
        total++;
        if (a_occ !== 3'd4) $display("FAIL full_occ: got %0d exp 4", a_occ);
        else passed++;
        a_pdata = 8'hA4;
        step();
        total++;
        if (a_occ !== 3'd4) $display("FAIL full_reject: got %0d exp 4", a_occ);
        else passed++;
        a_pvalid = 1'b0;
        a_nready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (a_nvalid !== 1'b1 || a_ndata !== 8'hA0 + 8'(i))
                $display("FAIL full_drain%0d: got %b/%h exp 1/%h",
                         i, a_nvalid, a_ndata, 8'hA0 + 8'(i));
            else passed++;
            step();
            if (i == 0) begin
                total++;
                if (a_pready !== 1'b1) $display("FAIL full_rise: got %b exp 1", a_pready);
                else passed++;
            end
        end
        total++;
        if (a_nvalid !== 1'b0) $display("FAIL full_empty: got %b exp 0", a_nvalid);
        else passed++;
        a_nready = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset_a();
        a_pvalid = 1'b1;
        a_nready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_pdata = 8'(i);
            step();
            total++;
            if (a_nvalid !== 1'b1 || a_ndata !== 8'(i) || a_occ !== 3'd1)
                $display("FAIL stream%0d: got %b/%h/%0d exp 1/%h/1",
                         i, a_nvalid, a_ndata, a_occ, 8'(i));
            else passed++;
        end
        a_pvalid = 1'b0;
        step();
        total++;
        if (a_nvalid !== 1'b0) $display("FAIL stream_end: got %b exp 0", a_nvalid);
        else passed++;
        a_nready = 1'b0;
    endtask

    task automatic test_wrap();
        b_reset  = 1'b1;
        b_flush  = 1'b0;
        b_pvalid = 1'b0;
        b_nready = 1'b0;
        b_pdata  = 8'h00;
        step();
        b_reset = 1'b0;
        for (int r = 0; r < 10; r++) begin
            b_pvalid = 1'b1;
            b_pdata  = 8'(2 * r + 1);
            step();
            b_pdata = 8'(2 * r + 2);
            step();
            b_pvalid = 1'b0;
            b_nready = 1'b1;
            for (int k = 1; k <= 2; k++) begin
                total++;
                if (b_nvalid !== 1'b1 || b_ndata !== 8'(2 * r + k))
                    $display("FAIL wrap_r%0d_%0d: got %b/%0d exp 1/%0d",
                             r, k, b_nvalid, b_ndata, 2 * r + k);
                else passed++;
                step();
            end
            b_nready = 1'b0;
        end
        total++;
        if (b_occ !== 2'd0) $display("FAIL wrap_occ: got %0d exp 0", b_occ);
        else passed++;
    endtask

    task automatic test_flush();
        reset_a();
        for (int i = 0; i < 3; i++) begin
            a_pvalid = 1'b1;
            a_pdata  = 8'hC0 + 8'(i);
            step();
        end
        a_flush  = 1'b1;
        a_pdata  = 8'h55;
        a_nready = 1'b1;
        step();
        a_flush  = 1'b0;
        a_pvalid = 1'b0;
        total++;
        if (a_occ !== 3'd0 || a_nvalid !== 1'b0 || a_pready !== 1'b1)
            $display("FAIL flush_state: got occ%0d v%b r%b exp 0/0/1",
                     a_occ, a_nvalid, a_pready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (a_nvalid !== 1'b0) $display("FAIL flush_leak%0d: got %b exp 0", i, a_nvalid);
            else passed++;
        end
        a_nready = 1'b0;
        a_pvalid = 1'b1;
        a_pdata  = 8'h66;
        step();
        a_pvalid = 1'b0;
        total++;
        if (a_nvalid !== 1'b1 || a_ndata !== 8'h66)
            $display("FAIL flush_after: got %b/%h exp 1/66", a_nvalid, a_ndata);
        else passed++;
    endtask

    task automatic test_reset_flush();
        reset_a();
        for (int i = 0; i < 4; i++) begin
            a_pvalid = 1'b1;
            a_pdata  = 8'hE0 + 8'(i);
            step();
        end
        a_pvalid = 1'b0;
        a_reset  = 1'b1;
        a_flush  = 1'b1;
        step();
        a_reset = 1'b0;
        a_flush = 1'b0;
        total++;
        if (a_nvalid !== 1'b0 || a_pready !== 1'b1 || a_occ !== 3'd0 || a_ndata !== 8'h00)
            $display("FAIL rf_state: got v%b r%b occ%0d d%h exp 0/1/0/00",
                     a_nvalid, a_pready, a_occ, a_ndata);
        else passed++;
        a_pvalid = 1'b1;
        a_pdata  = 8'h77;
        step();
        a_pvalid = 1'b0;
        total++;
        if (a_nvalid !== 1'b1 || a_ndata !== 8'h77 || a_occ !== 3'd1)
            $display("FAIL rf_push: got %b/%h/%0d exp 1/77/1", a_nvalid, a_ndata, a_occ);
        else passed++;
    endtask

    initial begin
        b_reset  = 1'b1;
        b_flush  = 1'b0;
        b_pvalid = 1'b0;
        b_nready = 1'b0;
        b_pdata  = 8'h00;
        test_reset();
        test_latency();
        test_full();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_reset_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
